// File: rtl/nibble_serial_sub16_if.sv
// rtl/nibble_serial_sub16_if.sv - operand/result bundle for the nibble-serial subtractor
interface nibble_serial_sub16_if;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        Bin;
  logic [15:0] Diff;
  logic        Bout;
  logic        zero;
  logic        neg;
  logic        ovf;
  logic        busy;
  logic        done;

  modport master (
    output start, A, B, Bin,
    input  Diff, Bout, zero, neg, ovf, busy, done
  );

  modport slave (
    input  start, A, B, Bin,
    output Diff, Bout, zero, neg, ovf, busy, done
  );
endinterface

// File: rtl/nibble_serial_sub16.sv
// rtl/nibble_serial_sub16.sv - 16-bit subtractor, one 4-bit lookahead nibble per cycle
module nibble_serial_sub16 (
  input  logic                  clk,
  input  logic                  rst,
  nibble_serial_sub16_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, next_state;
  logic [15:0] a_q, b_q;
  logic [1:0]  idx;
  logic        brw;
  logic [15:0] diff_q;
  logic        bout_q, zero_q, neg_q, ovf_q;
  logic        accept;
  logic [4:0]  nib;
  logic [15:0] diff_nxt;

  // Returns {borrow_out, diff[3:0]}; borrows resolved by lookahead, not ripple.
  function automatic logic [4:0] nib_sub(input logic [3:0] a, input logic [3:0] b,
                                         input logic bi);
    logic [3:0] g, p;
    logic [4:0] c;
    g    = ~a & b;
    p    = ~(a ^ b);
    c[0] = bi;
    c[1] = g[0] | (p[0] & bi);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bi);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & bi);
    return {c[4], a ^ b ^ c[3:0]};
  endfunction

  assign accept = bus.start && (state != RUN);
  assign nib    = nib_sub(a_q[{idx, 2'b00} +: 4], b_q[{idx, 2'b00} +: 4], brw);

  always_comb begin
    diff_nxt                     = diff_q;
    diff_nxt[{idx, 2'b00} +: 4]  = nib[3:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = RUN;
      RUN:     if (idx == 2'd3) next_state = DONE;
      DONE:    next_state = accept ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      brw    <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_q <= bus.A;
      b_q <= bus.B;
      brw <= bus.Bin;
      idx <= '0;
    end else if (state == RUN) begin
      diff_q <= diff_nxt;
      brw    <= nib[4];
      idx    <= idx + 2'd1;
      // Flags use the freshly completed word, not the stale Diff register.
      if (idx == 2'd3) begin
        bout_q <= nib[4];
        zero_q <= (diff_nxt == 16'h0000);
        neg_q  <= diff_nxt[15];
        ovf_q  <= (a_q[15] != b_q[15]) && (diff_nxt[15] != a_q[15]);
      end
    end
  end

  assign bus.Diff = diff_q;
  assign bus.Bout = bout_q;
  assign bus.zero = zero_q;
  assign bus.neg  = neg_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);

endmodule

// File: tb/tb_nibble_serial_sub16.sv
// tb/tb_nibble_serial_sub16.sv - scoreboard bench for nibble_serial_sub16
module tb_nibble_serial_sub16;

  typedef struct packed {
    logic [15:0] diff;
    logic        bout;
    logic        zero;
    logic        neg;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  nibble_serial_sub16_if bus ();

  nibble_serial_sub16 dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  res_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    res_t r;
    int   full;
    full   = int'(a) - int'(b) - int'(bin);
    r.diff = full[15:0];
    r.bout = (int'(a) < int'(b) + int'(bin));
    r.zero = (r.diff == 16'h0000);
    r.neg  = r.diff[15];
    r.ovf  = (a[15] != b[15]) && (r.diff[15] != a[15]);
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("Diff", {16'h0, bus.Diff}, {16'h0, e.diff});
        chk("Bout", {31'h0, bus.Bout}, {31'h0, e.bout});
        chk("zero", {31'h0, bus.zero}, {31'h0, e.zero});
        chk("neg",  {31'h0, bus.neg},  {31'h0, e.neg});
        chk("ovf",  {31'h0, bus.ovf},  {31'h0, e.ovf});
      end
    end
  end

  task automatic scramble();
    bus.A   = 16'($urandom);
    bus.B   = 16'($urandom);
    bus.Bin = 1'($urandom);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_Diff"}, {16'h0, bus.Diff}, 32'h0);
    chk({tag, "_flags"}, {28'h0, bus.Bout, bus.zero, bus.neg, bus.ovf}, 32'h0);
    chk({tag, "_busy_done"}, {30'h0, bus.busy, bus.done}, 32'h0);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic bin);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.Bin   = bin;
    @(posedge clk);
    exp_q.push_back(model(a, b, bin));
    @(negedge clk);
    bus.start = 1'b0;
    scramble();
  endtask

  // Full operation with latency checks; chain leaves us in the DONE cycle for a
  // back-to-back issue, inject pulses start during the first two RUN cycles.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input bit chain, input bit inject);
    issue(a, b, bin);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      chk("busy_in_run", {31'h0, bus.busy}, 32'd1);
      chk("done_in_run", {31'h0, bus.done}, 32'd0);
      bus.start = inject && (k <= 2);
      scramble();
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_at_done", {31'h0, bus.busy}, 32'd0);
    chk("done_latency", {31'h0, bus.done}, 32'd1);
    if (!chain) begin
      @(negedge clk);
      chk("done_one_cycle", {31'h0, bus.done}, 32'd0);
      chk("idle_not_busy", {31'h0, bus.busy}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.A     = 16'h0;
    bus.B     = 16'h0;
    bus.Bin   = 1'b0;
    #3;
    check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("idle");

    run_op(16'h1234, 16'h0234, 1'b0, 1'b0, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(16'h5555, 16'h5554, 1'b1, 1'b1, 1'b0);
    run_op(16'h0010, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'hFFFF, 1'b1, 1'b0, 1'b1);

    // Asynchronous abort two RUN cycles in.
    issue(16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_outputs_zero("async_rst");
    void'(exp_q.pop_back());
    repeat (3) @(negedge clk);
    check_outputs_zero("rst_held");
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("after_rst");
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (n % 8 == 0) rb = ra;
      run_op(ra, rb, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
